regfile_2r1w_sync: RTL and testbench
====================================

Name: regfile_2r1w_sync

Overview:
- 2^ADDR_W x WIDTH register file: one write port, two independent registered read ports (A, B).
- Serves the processor's decode stage; writeback drives the write port.
- Entry 0 is hardwired to zero.
- Each read port has a request/valid handshake with 1-cycle latency and optional same-edge write-to-read bypass.

Parameters:
WIDTH, 32, data width of each entry
ADDR_W, 5, address width; depth = 2^ADDR_W entries
BYPASS, 1, 1 = a read on the same edge as a write to the same address returns the new data; 0 = returns the old data

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
ctrl_writeEnable  input  1  write strobe, sampled on rising edge
ctrl_writeReg  input  ADDR_W  write address
data_writeReg  input  WIDTH  write data
rd_en_A  input  1  read request, port A
ctrl_readRegA  input  ADDR_W  read address, port A
data_readRegA  output  WIDTH  registered read data, port A
valid_A  output  1  port A data produced by the previous edge's request
rd_en_B  input  1  read request, port B
ctrl_readRegB  input  ADDR_W  read address, port B
data_readRegB  output  WIDTH  registered read data, port B
valid_B  output  1  port B data produced by the previous edge's request

Behaviour:
- Reset (async, any time, including mid-operation):
  - all entries cleared to 0
  - data_readRegA/B = 0, valid_A/B = 0
  - takes effect immediately, without waiting for a clock edge
  - first write/read is accepted on the first rising edge after reset deasserts
- Write:
  - on a rising edge with ctrl_writeEnable=1 and ctrl_writeReg!=0, entry[ctrl_writeReg] <= data_writeReg
  - writes to address 0 are silently dropped; entry 0 always reads 0
- Read (per port, independent and identical):
  - on a rising edge with rd_en=1, the data register loads entry[addr] and valid <= 1
  - on an edge with rd_en=0, valid <= 0 and the data register holds its previous value
  - latency: exactly 1 cycle; back-to-back requests give valid continuously high with new data every cycle
- Same-edge write and read to the same nonzero address:
  - BYPASS=1: read data = data_writeReg
  - BYPASS=0: read data = prior entry contents
  - the write itself completes in both cases
- Read of address 0: returns 0 regardless of any concurrent write to 0, including when BYPASS=1.
- Both ports may read the same address on the same edge; both return identical data.
- No backpressure. The consumer must capture data while valid=1 or rely on the hold value.
- No X on any output after reset. Out-of-range addresses cannot occur (full ADDR_W decode).

Test Plan:
- Assert reset mid-run after writing 0xDEADBEEF to r5; read r5 on port A -> data_readRegA=0x00000000 immediately on reset, valid_A=0; the post-reset read of r5 returns 0.
- Write 0x12345678 to r7 at edge k; rd_en_A with addr 7 at edge k+1 -> data_readRegA=0x12345678 and valid_A=1 after edge k+1; valid_A=0 after edge k+2 with rd_en_A=0, data held.
- Write 0xFFFFFFFF to r0, then read r0 on both ports -> both return 0x00000000 with valid=1.
- BYPASS=1: r3=0x11, then write 0x22 to r3 and read r3 on port B on the same edge -> data_readRegB=0x22.
- BYPASS=0: same stimulus -> data_readRegB=0x11; the next read returns 0x22.
- Write r1..r31 with value i*3, then read r31 (port A) and r1 (port B) on the same edge, then streamed reads on every cycle for 31 cycles -> correct value every cycle, valid continuously 1, ports independent.

Source files
------------

// File: rtl/regfile_2r1w_sync.sv
// Two-read, one-write register file with registered read ports and optional
// same-edge write-to-read bypass. Entry 0 always reads as zero.
module regfile_2r1w_sync #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [WIDTH-1:0]  data_writeReg,
   input  logic              rd_en_A,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   output logic [WIDTH-1:0]  data_readRegA,
   output logic              valid_A,
   input  logic              rd_en_B,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [WIDTH-1:0]  data_readRegB,
   output logic              valid_B
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;
   logic             wr_ok;

   // Address 0 wins over the bypass so a dropped write never leaks to a reader.
   function automatic logic [WIDTH-1:0] read_entry(
      input logic [ADDR_W-1:0] addr,
      input logic              wr,
      input logic [ADDR_W-1:0] waddr,
      input logic [WIDTH-1:0]  wdata,
      input logic [WIDTH-1:0]  stored
   );
      logic [WIDTH-1:0] value;
      value = stored;
      if (addr == '0)
         value = '0;
      else if ((BYPASS != 0) && wr && (waddr == addr))
         value = wdata;
      return value;
   endfunction

   assign wr_ok = ctrl_writeEnable && (ctrl_writeReg != '0);

   always_comb begin
      rdata_a = read_entry(ctrl_readRegA, wr_ok, ctrl_writeReg, data_writeReg,
                           regs[ctrl_readRegA]);
      rdata_b = read_entry(ctrl_readRegB, wr_ok, ctrl_writeReg, data_writeReg,
                           regs[ctrl_readRegB]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         data_readRegA <= '0;
         data_readRegB <= '0;
         valid_A       <= 1'b0;
         valid_B       <= 1'b0;
      end else begin
         if (wr_ok)
            regs[ctrl_writeReg] <= data_writeReg;
         valid_A <= rd_en_A;
         valid_B <= rd_en_B;
         if (rd_en_A)
            data_readRegA <= rdata_a;
         if (rd_en_B)
            data_readRegB <= rdata_b;
      end
   end

endmodule

// File: tb/tb_regfile_2r1w_sync.sv
// Randomized and directed bench for regfile_2r1w_sync; drives a bypassing and
// a non-bypassing instance with the same stimulus against an array model.
module tb_regfile_2r1w_sync;

   logic        clock;
   logic        reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        rd_en_A;
   logic [4:0]  ctrl_readRegA;
   logic        rd_en_B;
   logic [4:0]  ctrl_readRegB;

   logic [31:0] data_readRegA, data_readRegB, nb_data_A, nb_data_B;
   logic        valid_A, valid_B, nb_valid_A, nb_valid_B;

   int total = 0;
   int bad   = 0;

   // Model state: architectural contents plus expected outputs of each instance.
   logic [31:0] ref_mem [32];
   logic [31:0] exp_a, exp_b, exp_nb_a, exp_nb_b;
   logic        exp_va, exp_vb;

   regfile_2r1w_sync #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut (
      .clock(clock), .reset(reset),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg),
      .rd_en_A(rd_en_A), .ctrl_readRegA(ctrl_readRegA),
      .data_readRegA(data_readRegA), .valid_A(valid_A),
      .rd_en_B(rd_en_B), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegB(data_readRegB), .valid_B(valid_B)
   );

   regfile_2r1w_sync #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
      .clock(clock), .reset(reset),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg),
      .rd_en_A(rd_en_A), .ctrl_readRegA(ctrl_readRegA),
      .data_readRegA(nb_data_A), .valid_A(nb_valid_A),
      .rd_en_B(rd_en_B), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegB(nb_data_B), .valid_B(nb_valid_B)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] model_read(input logic [4:0] addr, input bit bypass);
      if (addr == 0) return 32'h0;
      if (bypass && ctrl_writeEnable && ctrl_writeReg == addr) return data_writeReg;
      return ref_mem[addr];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      exp_a = 0; exp_b = 0; exp_nb_a = 0; exp_nb_b = 0;
      exp_va = 0; exp_vb = 0;
   endtask

   // One clock edge: advance the model, then settle just past the edge.
   task automatic tick();
      @(posedge clock);
      if (rd_en_A) begin
         exp_a    = model_read(ctrl_readRegA, 1'b1);
         exp_nb_a = model_read(ctrl_readRegA, 1'b0);
      end
      if (rd_en_B) begin
         exp_b    = model_read(ctrl_readRegB, 1'b1);
         exp_nb_b = model_read(ctrl_readRegB, 1'b0);
      end
      exp_va = rd_en_A;
      exp_vb = rd_en_B;
      if (ctrl_writeEnable && ctrl_writeReg != 0) ref_mem[ctrl_writeReg] = data_writeReg;
      #1;
   endtask

   task automatic idle();
      ctrl_writeEnable = 0; ctrl_writeReg = 0; data_writeReg = 0;
      rd_en_A = 0; ctrl_readRegA = 0; rd_en_B = 0; ctrl_readRegB = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      model_clear();
      #1;
      total++;
      if (data_readRegA !== 0 || valid_A !== 0 || data_readRegB !== 0 || valid_B !== 0) begin
         bad++;
         $display("FAIL reset_initial: A=%h/%b B=%h/%b required 0/0", data_readRegA, valid_A, data_readRegB, valid_B);
      end
      @(negedge clock);
      reset = 1'b0;
      ctrl_writeEnable = 1; ctrl_writeReg = 5; data_writeReg = 32'hDEADBEEF;
      tick();
      idle();
      rd_en_A = 1; ctrl_readRegA = 5;
      tick();
      total++;
      if (data_readRegA !== 32'hDEADBEEF || valid_A !== 1) begin
         bad++;
         $display("FAIL reset_preload: A=%h/%b required deadbeef/1", data_readRegA, valid_A);
      end
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      total++;
      if (data_readRegA !== 0 || valid_A !== 0 || nb_data_A !== 0 || nb_valid_A !== 0) begin
         bad++;
         $display("FAIL reset_async: A=%h/%b nbA=%h/%b required 0/0", data_readRegA, valid_A, nb_data_A, nb_valid_A);
      end
      @(negedge clock);
      reset = 1'b0;
      tick();
      total++;
      if (data_readRegA !== 0 || valid_A !== 1) begin
         bad++;
         $display("FAIL reset_post_read: A=%h/%b required 0/1", data_readRegA, valid_A);
      end
      idle();
   endtask

   task automatic test_write_read();
      ctrl_writeEnable = 1; ctrl_writeReg = 7; data_writeReg = 32'h12345678;
      tick();
      idle();
      rd_en_A = 1; ctrl_readRegA = 7;
      tick();
      total++;
      if (data_readRegA !== 32'h12345678 || valid_A !== 1) begin
         bad++;
         $display("FAIL wr_rd_latency: A=%h/%b required 12345678/1", data_readRegA, valid_A);
      end
      idle();
      ctrl_readRegA = 3;
      tick();
      total++;
      if (data_readRegA !== 32'h12345678 || valid_A !== 0) begin
         bad++;
         $display("FAIL wr_rd_hold: A=%h/%b required 12345678/0", data_readRegA, valid_A);
      end
   endtask

   task automatic test_zero();
      ctrl_writeEnable = 1; ctrl_writeReg = 0; data_writeReg = 32'hFFFFFFFF;
      rd_en_A = 1; ctrl_readRegA = 0; rd_en_B = 1; ctrl_readRegB = 0;
      tick();
      total++;
      if (data_readRegA !== 0 || data_readRegB !== 0 || valid_A !== 1 || valid_B !== 1) begin
         bad++;
         $display("FAIL zero_same_edge: A=%h/%b B=%h/%b required 0/1", data_readRegA, valid_A, data_readRegB, valid_B);
      end
      ctrl_writeEnable = 0;
      tick();
      total++;
      if (data_readRegA !== 0 || data_readRegB !== 0 || nb_data_A !== 0 || nb_data_B !== 0) begin
         bad++;
         $display("FAIL zero_after: A=%h B=%h nbA=%h nbB=%h required 0", data_readRegA, data_readRegB, nb_data_A, nb_data_B);
      end
      idle();
   endtask

   task automatic test_bypass();
      ctrl_writeEnable = 1; ctrl_writeReg = 3; data_writeReg = 32'h11;
      tick();
      data_writeReg = 32'h22; rd_en_B = 1; ctrl_readRegB = 3;
      tick();
      total++;
      if (data_readRegB !== 32'h22 || valid_B !== 1) begin
         bad++;
         $display("FAIL bypass_on: B=%h/%b required 22/1", data_readRegB, valid_B);
      end
      total++;
      if (nb_data_B !== 32'h11 || nb_valid_B !== 1) begin
         bad++;
         $display("FAIL bypass_off: B=%h/%b required 11/1", nb_data_B, nb_valid_B);
      end
      ctrl_writeEnable = 0;
      tick();
      total++;
      if (nb_data_B !== 32'h22 || data_readRegB !== 32'h22) begin
         bad++;
         $display("FAIL bypass_next: nbB=%h B=%h required 22", nb_data_B, data_readRegB);
      end
      idle();
   endtask

   task automatic test_stream();
      for (int i = 1; i < 32; i++) begin
         ctrl_writeEnable = 1; ctrl_writeReg = 5'(i); data_writeReg = 32'(i * 3);
         tick();
      end
      idle();
      rd_en_A = 1; ctrl_readRegA = 31; rd_en_B = 1; ctrl_readRegB = 1;
      tick();
      total++;
      if (data_readRegA !== 32'd93 || data_readRegB !== 32'd3 || valid_A !== 1 || valid_B !== 1) begin
         bad++;
         $display("FAIL stream_first: A=%0d/%b B=%0d/%b required 93/1 3/1", data_readRegA, valid_A, data_readRegB, valid_B);
      end
      for (int i = 1; i < 32; i++) begin
         ctrl_readRegA = 5'(i); ctrl_readRegB = 5'(32 - i);
         tick();
         total++;
         if (data_readRegA !== 32'(i * 3) || data_readRegB !== 32'((32 - i) * 3) ||
             valid_A !== 1 || valid_B !== 1 || nb_data_A !== data_readRegA || nb_valid_B !== 1) begin
            bad++;
            $display("FAIL stream_%0d: A=%0d/%b B=%0d/%b required %0d/1 %0d/1", i,
                     data_readRegA, valid_A, data_readRegB, valid_B, i * 3, (32 - i) * 3);
         end
      end
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         ctrl_writeEnable = 1'($urandom_range(0, 1));
         ctrl_writeReg    = 5'($urandom_range(0, 7));
         data_writeReg    = $urandom;
         rd_en_A          = 1'($urandom_range(0, 3) != 0);
         ctrl_readRegA    = 5'($urandom_range(0, 7));
         rd_en_B          = 1'($urandom_range(0, 3) != 0);
         ctrl_readRegB    = ($urandom_range(0, 3) == 0) ? ctrl_readRegA : 5'($urandom_range(0, 7));
         tick();
         total++;
         if (data_readRegA !== exp_a || valid_A !== exp_va || data_readRegB !== exp_b || valid_B !== exp_vb) begin
            bad++;
            $display("FAIL rand_byp_%0d: A=%h/%b B=%h/%b required %h/%b %h/%b", n,
                     data_readRegA, valid_A, data_readRegB, valid_B, exp_a, exp_va, exp_b, exp_vb);
         end
         total++;
         if (nb_data_A !== exp_nb_a || nb_valid_A !== exp_va || nb_data_B !== exp_nb_b || nb_valid_B !== exp_vb) begin
            bad++;
            $display("FAIL rand_nobyp_%0d: A=%h/%b B=%h/%b required %h/%b %h/%b", n,
                     nb_data_A, nb_valid_A, nb_data_B, nb_valid_B, exp_nb_a, exp_va, exp_nb_b, exp_vb);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero();
      test_bypass();
      test_stream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
